// File: rtl/writeback_stage.sv
// writeback_stage: writer side of the Y86 register file.
// Accepts one retiring instruction per handshake from the memory stage.
// E and M results are serialized onto a single write port, E first.
// Any non-AOK status freezes the stage until reset.
module writeback_stage #(
  parameter int         DATA_W = 32,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_stat,
  input  logic [3:0]        in_dstE,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [3:0]        in_dstM,
  input  logic [DATA_W-1:0] in_valM,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              retire,
  output logic [31:0]       retired_cnt,
  output logic              halted,
  output logic [2:0]        stat_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR1  = 2'd1;
  localparam logic [1:0] S_WR2  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [2:0] STAT_AOK = 3'd1;

  logic [1:0]        r_state;
  logic [3:0]        r_dstE;
  logic [3:0]        r_dstM;
  logic [DATA_W-1:0] r_valE;
  logic [DATA_W-1:0] r_valM;
  logic [31:0]       r_retired_cnt;
  logic              r_halted;
  logic [2:0]        r_stat;

  logic w_accept;
  logic w_has_e;
  logic w_has_m;
  logic w_two_writes;

  assign w_accept     = in_valid && in_ready;
  assign w_has_e      = (r_dstE != RNONE);
  assign w_has_m      = (r_dstM != RNONE);
  assign w_two_writes = w_has_e && w_has_m;

  assign retired_cnt = r_retired_cnt;
  assign halted      = r_halted;
  assign stat_out    = r_stat;

  // Handshake and write-port drive, decoded from state and latched fields; reset masks all of it.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = RNONE;
    wr_data  = '0;
    retire   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: in_ready = 1'b1;
        S_WR1: begin
          // E has priority so that M is always the final value when both target one register
          if (w_has_e) begin
            wr_en   = 1'b1;
            wr_addr = r_dstE;
            wr_data = r_valE;
          end else if (w_has_m) begin
            wr_en   = 1'b1;
            wr_addr = r_dstM;
            wr_data = r_valM;
          end
          retire = !w_two_writes;
        end
        S_WR2: begin
          wr_en   = 1'b1;
          wr_addr = r_dstM;
          wr_data = r_valM;
          retire  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control path: state sequencing, retire counter and sticky halt status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_retired_cnt <= '0;
      r_halted      <= 1'b0;
      r_stat        <= STAT_AOK;
    end else begin
      if (retire) r_retired_cnt <= r_retired_cnt + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (in_stat == STAT_AOK) begin
              r_state <= S_WR1;
            end else begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
              r_stat   <= in_stat;
            end
          end
        end
        S_WR1:   r_state <= w_two_writes ? S_WR2 : S_IDLE;
        S_WR2:   r_state <= S_IDLE;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Instruction fields latched at accept; contents are don't-care outside WR1/WR2.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dstE <= in_dstE;
      r_valE <= in_valE;
      r_dstM <= in_dstM;
      r_valM <= in_valM;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: expected register writes are queued when an
// instruction is issued and popped by a monitor as the write port fires.
module tb_writeback_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_stat;
  logic [3:0]        in_dstE;
  logic [DATA_W-1:0] in_valE;
  logic [3:0]        in_dstM;
  logic [DATA_W-1:0] in_valM;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              retire;
  logic [31:0]       retired_cnt;
  logic              halted;
  logic [2:0]        stat_out;

  writeback_stage #(.DATA_W(DATA_W), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_stat(in_stat),
    .in_dstE(in_dstE), .in_valE(in_valE), .in_dstM(in_dstM), .in_valM(in_valM),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .retire(retire), .retired_cnt(retired_cnt),
    .halted(halted), .stat_out(stat_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] rf[16];
  int                n_total = 0;
  int                n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {28'd0, wr_addr, wr_data}, 64'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr_sb", {60'd0, wr_addr}, {60'd0, w.a});
        chk("wr_data_sb", {32'd0, wr_data}, {32'd0, w.d});
      end
      rf[wr_addr] = wr_data;
    end
  end

  // Drive one instruction; returns 1ns into cycle N+1 (accept at edge N).
  task automatic issue(input logic [2:0] st, input logic [3:0] de, input logic [31:0] ve,
                       input logic [3:0] dm, input logic [31:0] vm);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_stat  = st;
    in_dstE  = de;
    in_valE  = ve;
    in_dstM  = dm;
    in_valM  = vm;
    @(negedge clk);
    chk("ready_at_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valE  = 32'hBAD0_BAD0;
    in_valM  = 32'hBAD1_BAD1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_addr", {60'd0, wr_addr}, 64'hF);
    chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
    chk("rst_retire", {63'd0, retire}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_cnt", {32'd0, retired_cnt}, 64'd0);
    chk("post_rst_halted", {63'd0, halted}, 64'd0);
    chk("post_rst_stat", {61'd0, stat_out}, 64'd1);
  endtask

  initial begin
    logic [31:0] cnt_before;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_stat  = 3'd1;
    in_dstE  = 4'hF;
    in_valE  = '0;
    in_dstM  = 4'hF;
    in_valM  = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // irmovq: single E write with retire in the same cycle
    push_wr(4'd3, 32'h1234_5678);
    issue(3'd1, 4'd3, 32'h1234_5678, 4'hF, 32'd0);
    @(negedge clk);
    chk("irm_wr_en", {63'd0, wr_en}, 64'd1);
    chk("irm_wr_addr", {60'd0, wr_addr}, 64'd3);
    chk("irm_wr_data", {32'd0, wr_data}, 64'h1234_5678);
    chk("irm_retire", {63'd0, retire}, 64'd1);
    @(negedge clk);
    chk("irm_ready", {63'd0, in_ready}, 64'd1);
    chk("irm_cnt", {32'd0, retired_cnt}, 64'd1);
    chk("irm_wr_idle", {63'd0, wr_en}, 64'd0);

    // popq %rbx: E then M, retire only with the second write
    push_wr(4'd4, 32'h100);
    push_wr(4'd3, 32'hDEAD);
    issue(3'd1, 4'd4, 32'h100, 4'd3, 32'hDEAD);
    @(negedge clk);
    chk("pop_wr1_addr", {60'd0, wr_addr}, 64'd4);
    chk("pop_wr1_retire", {63'd0, retire}, 64'd0);
    chk("pop_wr1_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("pop_wr2_addr", {60'd0, wr_addr}, 64'd3);
    chk("pop_wr2_retire", {63'd0, retire}, 64'd1);
    @(negedge clk);
    chk("pop_ready", {63'd0, in_ready}, 64'd1);
    chk("pop_cnt", {32'd0, retired_cnt}, 64'd2);
    chk("pop_rf3", {32'd0, rf[3]}, 64'hDEAD);
    chk("pop_rf4", {32'd0, rf[4]}, 64'h100);

    // popq %rsp: same register twice, M value must win
    push_wr(4'd4, 32'h108);
    push_wr(4'd4, 32'h55);
    issue(3'd1, 4'd4, 32'h108, 4'd4, 32'h55);
    repeat (3) @(negedge clk);
    chk("rsp_rf4", {32'd0, rf[4]}, 64'h55);
    chk("rsp_cnt", {32'd0, retired_cnt}, 64'd3);

    // nop: no write, immediate retire
    issue(3'd1, 4'hF, 32'h1, 4'hF, 32'h2);
    @(negedge clk);
    chk("nop_wr_en", {63'd0, wr_en}, 64'd0);
    chk("nop_wr_addr", {60'd0, wr_addr}, 64'hF);
    chk("nop_wr_data", {32'd0, wr_data}, 64'd0);
    chk("nop_retire", {63'd0, retire}, 64'd1);

    // mrmovq: single M write in WR1
    push_wr(4'd2, 32'd7);
    issue(3'd1, 4'hF, 32'h99, 4'd2, 32'd7);
    @(negedge clk);
    chk("mrm_wr_en", {63'd0, wr_en}, 64'd1);
    chk("mrm_wr_addr", {60'd0, wr_addr}, 64'd2);
    chk("mrm_retire", {63'd0, retire}, 64'd1);
    @(negedge clk);
    chk("mrm_cnt", {32'd0, retired_cnt}, 64'd5);
    chk("mrm_rf2", {32'd0, rf[2]}, 64'd7);

    // ADR status: halt with no write and no retire
    cnt_before = retired_cnt;
    issue(3'd3, 4'd2, 32'h77, 4'hF, 32'd0);
    @(negedge clk);
    chk("hlt_wr_en", {63'd0, wr_en}, 64'd0);
    chk("hlt_retire", {63'd0, retire}, 64'd0);
    chk("hlt_halted", {63'd0, halted}, 64'd1);
    chk("hlt_stat", {61'd0, stat_out}, 64'd3);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_stat  = 3'd1;
    in_dstE  = 4'd5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hlt_ready", {63'd0, in_ready}, 64'd0);
      chk("hlt_no_wr", {63'd0, wr_en}, 64'd0);
    end
    chk("hlt_cnt", {32'd0, retired_cnt}, {32'd0, cnt_before});
    chk("hlt_stat_hold", {61'd0, stat_out}, 64'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    do_reset();

    // Reset while the M write of popq %rbx is pending
    push_wr(4'd4, 32'h100);
    issue(3'd1, 4'd4, 32'h100, 4'd3, 32'hDEAD);
    @(negedge clk);
    chk("rwr_wr1_retire", {63'd0, retire}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rwr_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rwr_retire", {63'd0, retire}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rwr_cnt", {32'd0, retired_cnt}, 64'd0);
    chk("rwr_ready", {63'd0, in_ready}, 64'd1);
    chk("rwr_rf3", {32'd0, rf[3]}, 64'hDEAD);
    repeat (2) @(negedge clk);
    chk("rwr_quiet", {63'd0, wr_en}, 64'd0);

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.r_retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_cnt;
    #1;
    chk("wrap_preload", {32'd0, retired_cnt}, 64'hFFFF_FFFF);
    issue(3'd1, 4'hF, 32'd0, 4'hF, 32'd0);
    @(negedge clk);
    chk("wrap_retire", {63'd0, retire}, 64'd1);
    @(negedge clk);
    chk("wrap_cnt", {32'd0, retired_cnt}, 64'd0);

    chk("sb_drained", {32'd0, exp_q.size()}, 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case a sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
